// File: rtl/psel_pkg.sv
// Shared types for the rr_psel priority selector family.
package psel_pkg;
    typedef enum logic {PSEL_IDLE, PSEL_BUSY} psel_state_t;
endpackage

// File: rtl/rr_psel_pick.sv
// Combinational winner selection: rotate by ptr, priority-pick, rotate the index back.
module rr_psel_pick #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               rr_mode,
    input  logic               en,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_valid
);
    logic [IDX_W-1:0]   rot_amt;
    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W:0]     sum;
    logic               found;

    always_comb begin
        // Fixed mode ignores ptr so "highest index" means absolute index.
        rot_amt = rr_mode ? ptr : '0;
        rot     = NUM_REQ'({req, req} >> rot_amt);
        sel     = '0;
        found   = 1'b0;
        if (rr_mode) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (rot[i]) begin
                    sel   = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rot[i]) begin
                    sel   = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end
        // Modulo add without a divider; ptr < NUM_REQ so one subtract suffices.
        sum = {1'b0, sel} + {1'b0, rot_amt};
        if (sum >= (IDX_W + 1)'(NUM_REQ))
            sum = sum - (IDX_W + 1)'(NUM_REQ);
        win_valid = found & en;
        win_idx   = win_valid ? sum[IDX_W-1:0] : '0;
        win       = win_valid ? (NUM_REQ'(1) << win_idx) : '0;
    end
endmodule

// File: rtl/rr_psel.sv
// Registered fixed/round-robin priority selector with grant held until ack.
module rr_psel
    import psel_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic               rr_mode,
    input  logic               ack,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               req_up
);
    psel_state_t        state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [NUM_REQ-1:0] win;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;
    logic               release_g;
    logic [IDX_W:0]     inc;

    // ptr_d feeds the picker so a release and a new grant share one cycle.
    rr_psel_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req      (req),
        .ptr      (ptr_d),
        .rr_mode  (rr_mode),
        .en       (en),
        .win      (win),
        .win_idx  (win_idx),
        .win_valid(win_valid)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        release_g   = (state_q == PSEL_BUSY) && ack;
        inc         = {1'b0, gnt_idx_q} + 1'b1;
        if (inc >= (IDX_W + 1)'(NUM_REQ))
            inc = '0;
        if (release_g && rr_mode)
            ptr_d = inc[IDX_W-1:0];
        if (state_q == PSEL_IDLE || release_g) begin
            gnt_d       = win;
            gnt_idx_d   = win_idx;
            gnt_valid_d = win_valid;
            state_d     = win_valid ? PSEL_BUSY : PSEL_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= PSEL_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign req_up    = |req;
endmodule

// File: tb/tb_rr_psel.sv
// Scoreboarded random/directed bench for rr_psel at NUM_REQ=8 and NUM_REQ=5.
module tb_rr_psel;
    logic       clock = 1'b0;
    logic       reset, en, rr_mode, ack;
    logic [7:0] req;
    logic [7:0] gnt8;
    logic       gv8, up8;
    logic [2:0] gi8;
    logic [4:0] gnt5;
    logic       gv5, up5;
    logic [2:0] gi5;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] gnt8;
        logic       gv8;
        logic [2:0] gi8;
        logic       up8;
        logic [4:0] gnt5;
        logic       gv5;
        logic [2:0] gi5;
        logic       up5;
    } exp_t;
    exp_t sb[$];

    // Reference state: is a grant outstanding, to whom, and the rr pointer.
    bit b8 = 0, b5 = 0;
    int o8 = 0, o5 = 0, p8 = 0, p5 = 0;

    always #5 clock = ~clock;

    rr_psel #(.NUM_REQ(8)) u_dut8 (
        .clock(clock), .reset(reset), .en(en), .req(req), .rr_mode(rr_mode),
        .ack(ack), .gnt(gnt8), .gnt_valid(gv8), .gnt_idx(gi8), .req_up(up8)
    );

    rr_psel #(.NUM_REQ(5)) u_dut5 (
        .clock(clock), .reset(reset), .en(en), .req(req[4:0]), .rr_mode(rr_mode),
        .ack(ack), .gnt(gnt5), .gnt_valid(gv5), .gnt_idx(gi5), .req_up(up5)
    );

    function automatic int pick(int n, logic [7:0] r, int p, logic rr);
        if (rr) begin
            for (int k = 0; k < n; k++)
                if (r[(p + k) % n]) return (p + k) % n;
        end else begin
            for (int j = n - 1; j >= 0; j--)
                if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input int n, input logic r, input logic e,
                              input logic [7:0] q, input logic rr, input logic a,
                              inout bit busy, inout int own, inout int p);
        logic [7:0] rq;
        int w;
        rq = q & ((8'd1 << n) - 8'd1);
        if (!r) begin
            busy = 0; own = 0; p = 0;
        end else if (!busy || a) begin
            if (busy && rr) p = (own + 1) % n;
            w = pick(n, rq, p, rr);
            if (e && w >= 0) begin
                busy = 1; own = w;
            end else begin
                busy = 0; own = 0;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic [7:0] q,
                       input logic rr, input logic a);
        exp_t x;
        reset = r; en = e; req = q; rr_mode = rr; ack = a;
        model_step(8, r, e, q, rr, a, b8, o8, p8);
        model_step(5, r, e, q, rr, a, b5, o5, p5);
        x.gnt8 = b8 ? (8'd1 << o8) : 8'd0;
        x.gv8  = b8;
        x.gi8  = b8 ? 3'(o8) : 3'd0;
        x.up8  = |q;
        x.gnt5 = b5 ? (5'd1 << o5) : 5'd0;
        x.gv5  = b5;
        x.gi5  = b5 ? 3'(o5) : 3'd0;
        x.up5  = |q[4:0];
        sb.push_back(x);
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: registered outputs are presented every cycle, one entry per posedge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("gnt8", 32'(gnt8), 32'(x.gnt8));
                chk("gnt_valid8", 32'(gv8), 32'(x.gv8));
                chk("gnt_idx8", 32'(gi8), 32'(x.gi8));
                chk("req_up8", 32'(up8), 32'(x.up8));
                chk("gnt5", 32'(gnt5), 32'(x.gnt5));
                chk("gnt_valid5", 32'(gv5), 32'(x.gv5));
                chk("gnt_idx5", 32'(gi5), 32'(x.gi5));
                chk("req_up5", 32'(up5), 32'(x.up5));
            end
        end
    end

    initial begin
        // Reset dominates a full request vector and ack.
        cyc(0, 1, 8'hFF, 1, 1);
        cyc(0, 1, 8'hFF, 1, 1);
        cyc(1, 1, 8'hFF, 1, 0);
        // Round-robin sweep with ack every cycle: no bubbles.
        for (int i = 0; i < 10; i++) cyc(1, 1, 8'hFF, 1, 1);
        // Fixed priority, drop and re-raise req[5].
        cyc(0, 0, 8'h00, 0, 0);
        cyc(1, 1, 8'b0010_1001, 0, 0);
        cyc(1, 1, 8'b0010_1001, 0, 0);
        cyc(1, 1, 8'b0000_1001, 0, 1);
        cyc(1, 1, 8'b0010_1001, 0, 1);
        cyc(1, 1, 8'b0010_1001, 0, 0);
        // Hold with changing req and en low, then release into idle.
        cyc(0, 0, 8'h00, 1, 0);
        cyc(1, 1, 8'h04, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'h80, i[0], 0);
        cyc(1, 0, 8'h80, 1, 1);
        cyc(1, 0, 8'h80, 1, 1);
        // Pointer wrap and skip, including idx 4 -> 0 on the 5-wide instance.
        cyc(0, 0, 8'h00, 1, 0);
        cyc(1, 1, 8'h40, 1, 0);
        cyc(1, 1, 8'h81, 1, 1);
        cyc(1, 1, 8'h81, 1, 1);
        cyc(1, 1, 8'h81, 1, 0);
        cyc(0, 0, 8'h00, 1, 0);
        cyc(1, 1, 8'h10, 1, 0);
        cyc(1, 1, 8'h11, 1, 1);
        cyc(1, 1, 8'h11, 1, 0);
        // Reset with ack during an outstanding grant, pointer restarts at 0.
        cyc(1, 1, 8'h08, 1, 1);
        cyc(1, 1, 8'h08, 1, 0);
        cyc(0, 1, 8'h08, 1, 1);
        cyc(1, 1, 8'h18, 1, 0);
        cyc(1, 1, 8'h18, 1, 0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 49) != 0),
                ($urandom_range(0, 9) != 0),
                8'($urandom),
                (i < 300) ? 1'b1 : 1'($urandom),
                ($urandom_range(0, 9) < 4));
        end
        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
